// File: rtl/pc_gen_pkg.sv
// pc_gen_pkg: shared types and constants for the fetch-address generator.
// Holds the FSM state encoding and the default instruction-address bus width.
// Optional feature macro used by this slice: PC_ALIGN_CHECK_EN (undefined by
// default). When defined, pc_gen exposes a misalign output and loads redirect
// targets unmodified. When undefined, the low alignment bits of every target
// are cleared.
package pc_gen_pkg;

   // Default width of the instruction address bus.
   localparam int INST_ADDR_BUS_W = 32;

   // Fetch-address FSM states (2-bit encoding).
   typedef enum logic [1:0] {
      PC_BOOT = 2'b00,
      PC_RUN  = 2'b01,
      PC_PEND = 2'b10
   } pc_state_e;

   // Mask that selects the sub-instruction byte-offset bits of an address.
   function automatic logic [63:0] align_mask(input int inst_bytes);
      logic [63:0] m;
      m = 64'(inst_bytes) - 64'd1;
      return m;
   endfunction

endpackage

// File: rtl/pc_redirect_hold.sv
// pc_redirect_hold: redirect priority mux (flush over branch) plus the
// pending-branch holder used while the fetch stage is stalled.
// Macro PC_ALIGN_CHECK_EN: when undefined, redirect targets are aligned here
// by clearing their low byte-offset bits; when defined they pass unmodified.
module pc_redirect_hold
   import pc_gen_pkg::*;
#(
   parameter int ADDR_W     = INST_ADDR_BUS_W,
   parameter int INST_BYTES = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic [ADDR_W-1:0] flush_addr,
   input  logic              br,
   input  logic [ADDR_W-1:0] br_addr,
   input  logic              pend_load,
   input  logic              pend_clr,
   output logic              redir_valid,
   output logic [ADDR_W-1:0] redir_addr,
   output logic              pend_valid,
   output logic [ADDR_W-1:0] pend_addr
);

   logic [ADDR_W-1:0] sel_addr_s;
   logic [ADDR_W-1:0] br_tgt_s;
   logic [ADDR_W-1:0] pend_addr_r;
   logic              pend_valid_r;

   // Select the winning redirect target: flush always beats branch.
   always_comb begin
      sel_addr_s = br_addr;
      if (flush) begin
         sel_addr_s = flush_addr;
      end else begin
         sel_addr_s = br_addr;
      end
   end

`ifdef PC_ALIGN_CHECK_EN
   assign redir_addr = sel_addr_s;
   assign br_tgt_s   = br_addr;
`else
   localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(align_mask(INST_BYTES));
   assign redir_addr = sel_addr_s & ~ALIGN_MASK;
   assign br_tgt_s   = br_addr & ~ALIGN_MASK;
`endif

   assign redir_valid = flush | br;

   // Pending-branch register: the newest stalled branch overwrites any older one.
   always_ff @(posedge clk) begin
      if (rst) begin
         pend_valid_r <= 1'b0;
         pend_addr_r  <= {ADDR_W{1'b0}};
      end else if (pend_clr) begin
         pend_valid_r <= 1'b0;
         pend_addr_r  <= pend_addr_r;
      end else if (pend_load) begin
         pend_valid_r <= 1'b1;
         pend_addr_r  <= br_tgt_s;
      end else begin
         pend_valid_r <= pend_valid_r;
         pend_addr_r  <= pend_addr_r;
      end
   end

   assign pend_valid = pend_valid_r;
   assign pend_addr  = pend_addr_r;

endmodule

// File: rtl/pc_gen.sv
// pc_gen: fetch-address generator with reset vector, configurable stride,
// valid/ready handshake, flush/branch redirects and a pending-branch holder.
// Macro PC_ALIGN_CHECK_EN (undefined by default): adds the misalign output,
// which pulses with the redirected pc when its target has nonzero low bits.
module pc_gen
   import pc_gen_pkg::*;
#(
   parameter int                ADDR_W     = INST_ADDR_BUS_W,
   parameter logic [ADDR_W-1:0] RESET_VEC  = {ADDR_W{1'b0}},
   parameter int                INST_BYTES = 4,
   parameter int                STALL_W    = 6,
   parameter int                STALL_BIT  = 0
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [STALL_W-1:0] stall,
   input  logic               flush,
   input  logic [ADDR_W-1:0]  flush_addr,
   input  logic               br,
   input  logic [ADDR_W-1:0]  br_addr,
   input  logic               pc_ready,
   output logic [ADDR_W-1:0]  pc,
   output logic               pc_valid
`ifdef PC_ALIGN_CHECK_EN
   ,
   output logic               misalign
`endif
);

   localparam logic [ADDR_W-1:0] STRIDE = ADDR_W'(INST_BYTES);

   pc_state_e         state_r;
   pc_state_e         state_nx_s;
   logic [ADDR_W-1:0] pc_r;
   logic [ADDR_W-1:0] pc_nx_s;
   logic              pc_valid_r;
   logic              pc_valid_nx_s;
   logic              stall_bit_s;
   logic              adv_s;
   logic              pend_load_s;
   logic              pend_clr_s;
   logic              redir_valid_s;
   logic [ADDR_W-1:0] redir_addr_s;
   logic              pend_valid_s;
   logic [ADDR_W-1:0] pend_addr_s;
   logic              unused_stall_s;
`ifdef PC_ALIGN_CHECK_EN
   localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(align_mask(INST_BYTES));
   logic              mis_nx_s;
   logic              misalign_r;
`endif

   // Only one bit of the pipeline stall vector freezes this stage.
   assign stall_bit_s    = stall[STALL_BIT];
   assign unused_stall_s = ^stall;
   assign adv_s          = pc_valid_r & pc_ready & ~stall_bit_s;

   pc_redirect_hold #(
      .ADDR_W     (ADDR_W),
      .INST_BYTES (INST_BYTES)
   ) u_hold (
      .clk         (clk),
      .rst         (rst),
      .flush       (flush),
      .flush_addr  (flush_addr),
      .br          (br),
      .br_addr     (br_addr),
      .pend_load   (pend_load_s),
      .pend_clr    (pend_clr_s),
      .redir_valid (redir_valid_s),
      .redir_addr  (redir_addr_s),
      .pend_valid  (pend_valid_s),
      .pend_addr   (pend_addr_s)
   );

   // Next-state, next-pc and pending-holder control, in redirect priority order.
   always_comb begin
      state_nx_s    = state_r;
      pc_nx_s       = pc_r;
      pc_valid_nx_s = pc_valid_r;
      pend_load_s   = 1'b0;
      pend_clr_s    = 1'b0;
`ifdef PC_ALIGN_CHECK_EN
      mis_nx_s      = 1'b0;
`endif
      case (state_r)
         PC_BOOT: begin
            state_nx_s    = PC_RUN;
            pc_valid_nx_s = 1'b1;
         end
         PC_RUN: begin
            if (redir_valid_s && (flush || !stall_bit_s)) begin
               // Flush, or an unstalled branch: the offered pc is wrong-path.
               pc_nx_s       = redir_addr_s;
               pc_valid_nx_s = 1'b1;
`ifdef PC_ALIGN_CHECK_EN
               mis_nx_s      = |(redir_addr_s & ALIGN_MASK);
`endif
            end else if (br) begin
               // Branch while stalled: park it and withdraw the request.
               pend_load_s   = 1'b1;
               pc_valid_nx_s = 1'b0;
               state_nx_s    = PC_PEND;
            end else if (adv_s) begin
               pc_nx_s = pc_r + STRIDE;
            end else begin
               pc_nx_s = pc_r;
            end
         end
         PC_PEND: begin
            if (flush) begin
               pc_nx_s       = redir_addr_s;
               pc_valid_nx_s = 1'b1;
               pend_clr_s    = 1'b1;
               state_nx_s    = PC_RUN;
`ifdef PC_ALIGN_CHECK_EN
               mis_nx_s      = |(redir_addr_s & ALIGN_MASK);
`endif
            end else if (br) begin
               pend_load_s = 1'b1;
            end else if (!stall_bit_s && pend_valid_s) begin
               pc_nx_s       = pend_addr_s;
               pc_valid_nx_s = 1'b1;
               pend_clr_s    = 1'b1;
               state_nx_s    = PC_RUN;
`ifdef PC_ALIGN_CHECK_EN
               mis_nx_s      = |(pend_addr_s & ALIGN_MASK);
`endif
            end else begin
               pc_nx_s = pc_r;
            end
         end
         default: begin
            state_nx_s    = PC_BOOT;
            pc_valid_nx_s = 1'b0;
            pend_clr_s    = 1'b1;
         end
      endcase
   end

   // State, pc and valid registers; reset loads the reset vector.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r    <= PC_BOOT;
         pc_r       <= RESET_VEC;
         pc_valid_r <= 1'b0;
      end else begin
         state_r    <= state_nx_s;
         pc_r       <= pc_nx_s;
         pc_valid_r <= pc_valid_nx_s;
      end
   end

`ifdef PC_ALIGN_CHECK_EN
   // Misalign flag: one-cycle pulse alongside the redirected pc.
   always_ff @(posedge clk) begin
      if (rst) begin
         misalign_r <= 1'b0;
      end else begin
         misalign_r <= mis_nx_s;
      end
   end

   assign misalign = misalign_r;
`endif

   assign pc       = pc_r;
   assign pc_valid = pc_valid_r;

endmodule
